// File: rtl/vcii_sar_ctrl_if.sv
// Bus bundle between the SAR controller and its environment: the
// conversion request/abort controls, the comparator input and the
// DAC/result/status outputs.
//
// Handshake: start is a level request sampled only while the controller
// is idle; the conversion is accepted on the first rising edge that sees
// start=1 in idle (and abort=0). Completion is signalled by done, a single
// cycle pulse that coincides with result taking its new value. There is no
// back-pressure: the consumer must capture result on the done cycle or
// any time before the next done.
interface vcii_sar_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic         cont;
    logic         abort;
    logic         cmp;
    logic         sample_en;
    logic [N-1:0] dac_code;
    logic [N-1:0] result;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    modport master (
        output start, cont, abort, cmp,
        input  sample_en, dac_code, result, busy, done, state_dbg
    );

    modport slave (
        input  start, cont, abort, cmp,
        output sample_en, dac_code, result, busy, done, state_dbg
    );
endinterface

// File: rtl/vcii_sar_ctrl.sv
// Successive-approximation controller for a VCII current-conveyor front end.
// Sequence per conversion: track (SAMPLE), N binary-search bit trials
// (TRIAL), then one DONE cycle that publishes the result. The comparator
// output is asynchronous and is only used after a two-flop synchronizer;
// each trial is SETTLE_CYC long so the synchronized decision reflects the
// DAC code driven at the start of that trial. All outputs are registered.
module vcii_sar_ctrl #(
    parameter int N          = 8,
    parameter int SAMPLE_CYC = 4,
    parameter int SETTLE_CYC = 3
) (
    input  logic               clk,
    input  logic               rst,
    vcii_sar_ctrl_if.slave     bus
);
    localparam int MAXC = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        TRIAL  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N-1:0]   dac_q, dac_d;
    logic [N-1:0]   result_q, result_d;
    logic [N-1:0]   trial_code;
    logic           done_q, done_d;
    logic           sample_en_q, sample_en_d;
    logic           busy_q, busy_d;
    logic           cmp_s1, cmp_s2;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_s1 <= 1'b0;
            cmp_s2 <= 1'b0;
        end else begin
            cmp_s1 <= bus.cmp;
            cmp_s2 <= cmp_s1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            dac_q       <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            sample_en_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dac_q       <= dac_d;
            result_q    <= result_d;
            done_q      <= done_d;
            sample_en_q <= sample_en_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        dac_d      = dac_q;
        result_d   = result_q;
        done_d     = 1'b0;
        trial_code = dac_q;
        // Decision for the bit under trial: keep it only if vin >= DAC.
        if (!cmp_s2) begin
            trial_code[idx_q] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end
            end
            SAMPLE: begin
                if (cnt_q == CW'(SAMPLE_CYC - 1)) begin
                    state_d        = TRIAL;
                    cnt_d          = '0;
                    idx_d          = IW'(N - 1);
                    dac_d          = '0;
                    dac_d[N-1]     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TRIAL: begin
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    cnt_d = '0;
                    dac_d = trial_code;
                    if (idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d                    = idx_q - IW'(1);
                        dac_d[idx_q - IW'(1)]    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                result_d = dac_q;
                done_d   = 1'b1;
                cnt_d    = '0;
                state_d  = bus.cont ? SAMPLE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything, including publishing a finished code.
        if (bus.abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            idx_d    = '0;
            dac_d    = dac_q;
            result_d = result_q;
            done_d   = 1'b0;
        end

        sample_en_d = (state_d == SAMPLE);
        busy_d      = (state_d != IDLE);
    end

    assign bus.sample_en = sample_en_q;
    assign bus.dac_code  = dac_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;
endmodule
